ieeedrv_trkbuf_ctl: RTL
=======================

Name: ieeedrv_trkbuf_ctl

Overview:
Track-buffer SD sequencer placed directly downstream of the drive stepper/track logic in the 4040/8250 IEEE drive. It consumes the current track number, the track-changing flag and the save_track toggle. From these it drives the MiSTer SD block interface to write the dirty track back and to load the newly selected track into the track buffer. Each track occupies a fixed number of consecutive 512-byte SD blocks in the image.

Parameters:
TRACK_BLOCKS, 16, SD blocks per track; must be a power of 2; BLK_W = log2(TRACK_BLOCKS)
MAX_TRACK, 154, highest valid track number; valid tracks are 1..MAX_TRACK

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
img_mounted  in  1  level: image present
mounted  in  1  one-cycle pulse: new image mounted
img_readonly  in  1  level: image write-protected
track  in  8  requested track from stepper logic (1-based)
track_changing  in  1  stepper still settling; do not load
save_track  in  1  toggle: each edge requests a write-back of the loaded track
sd_lba  out  32  SD block address
sd_rd  out  1  SD read request
sd_wr  out  1  SD write request
sd_ack  in  1  SD transfer active
buf_blk  out  BLK_W  block index within the track buffer for the current transfer
cur_track  out  8  track held in the buffer
track_valid  out  1  buffer holds cur_track data
busy  out  1  state != IDLE

Behaviour:
- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, buf_blk=0, cur_track=0, track_valid=0, busy=0, save_pending=0. State=IDLE. save_track edge detector loads the current save_track value, so no false edge occurs at reset.
- save_track edge detection: register save_old each cycle. Any save_track != save_old sets save_pending, including in states other than IDLE.
- mounted pulse: track_valid<=0, save_pending<=0. If not IDLE, abort: drop sd_rd/sd_wr immediately and go to IDLE.
- States: IDLE, REQ, WAIT_ACK, WAIT_DONE.
- IDLE priority:
  1. save_pending & track_valid & img_mounted & !img_readonly -> op=WRITE, xfer_track=cur_track, buf_blk=0, clear save_pending, go REQ.
  2. save_pending with the other conditions of rule 1 false -> clear save_pending and stay IDLE; the save is dropped.
  3. img_mounted & !track_changing & 1<=track<=MAX_TRACK & (!track_valid | track!=cur_track) -> op=READ, xfer_track=track, track_valid<=0, buf_blk=0, go REQ.
  4. Otherwise stay IDLE.
- Out-of-range tracks (0 or >MAX_TRACK) are never loaded; the buffer keeps its previous contents and validity.
- REQ: sd_lba <= (xfer_track-1)*TRACK_BLOCKS + buf_blk, zero-extended to 32 bits. In the same cycle assert sd_rd (READ) or sd_wr (WRITE). Go WAIT_ACK.
- WAIT_ACK: hold the request and sd_lba stable until sd_ack=1, then deassert the request. Go WAIT_DONE.
- WAIT_DONE: wait for sd_ack=0.
  - If buf_blk != TRACK_BLOCKS-1: increment buf_blk and go REQ.
  - Else, for READ: cur_track<=xfer_track, track_valid<=1. For WRITE: cur_track is unchanged. Go IDLE.
- A track change during a WRITE does not abort it. The load follows once IDLE is reached, so dirty data is always written before the buffer is overwritten.
- A save toggle during a READ is kept pending. It is serviced after the load, against the newly loaded track.
- Minimum gap between block requests: 1 cycle (the REQ state).
- busy is combinational from state.
- img_mounted falling in IDLE: track_valid<=0. A transfer in progress completes normally.

Test Plan:
- Mount, track=18, track_changing=0: expect 16 reads at LBAs 272..287; then track_valid=1, cur_track=18, busy=0.
- track 18->19 with track_changing=1 for 1000 cycles: no sd_rd while track_changing=1. Afterwards expect reads at LBAs 288..303 and cur_track=19.
- Toggle save_track with track 19 loaded: expect 16 sd_wr at LBAs 288..303 and cur_track stays 19. A second toggle during the writes causes exactly one more 16-block write pass.
- Toggle save_track and change track to 20 in the same cycle: all 16 writes (LBAs 288..303) complete before the first read (LBA 304).
- img_readonly=1, toggle save_track: no sd_wr issued; save_pending clears; busy stays 0.
- Assert reset (or a mounted pulse) while WAIT_ACK of block 5: sd_rd=0 the next cycle, state IDLE, track_valid=0. After reset with the image present, the load restarts from block 0.

Source files
------------

// File: rtl/ieeedrv_trkbuf_ctl.sv
// Track-buffer SD sequencer for the IEEE drive: writes the dirty track back and loads the
// selected track, one 512-byte block per SD request, TRACK_BLOCKS blocks per track.
module ieeedrv_trkbuf_ctl #(
  parameter int  TRACK_BLOCKS = 16,
  parameter int  MAX_TRACK    = 154,
  localparam int BLK_W        = $clog2(TRACK_BLOCKS)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             img_mounted,
  input  logic             mounted,
  input  logic             img_readonly,
  input  logic [7:0]       track,
  input  logic             track_changing,
  input  logic             save_track,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  output logic [BLK_W-1:0] buf_blk,
  output logic [7:0]       cur_track,
  output logic             track_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  localparam logic [31:0] BLOCKS_32 = 32'(TRACK_BLOCKS);

  state_t           state_q;
  logic             op_wr_q;
  logic [7:0]       xfer_track_q;
  logic [BLK_W-1:0] buf_blk_q;
  logic [31:0]      sd_lba_q;
  logic             sd_rd_q;
  logic             sd_wr_q;
  logic [7:0]       cur_track_q;
  logic             track_valid_q;
  logic             save_old_q;
  logic             save_pending_q;

  logic             save_edge;
  logic             save_req;
  logic             track_ok;
  logic             load_req;
  logic             can_save;
  logic             last_blk;
  logic [31:0]      lba_d;

  // A toggle arriving in the same cycle as a track change must still win over the load.
  assign save_edge = save_track ^ save_old_q;
  assign save_req  = save_pending_q | save_edge;
  assign track_ok  = (track >= 8'd1) && (track <= 8'(MAX_TRACK));
  assign load_req  = img_mounted & ~track_changing & track_ok &
                     (~track_valid_q | (track != cur_track_q));
  assign can_save  = track_valid_q & img_mounted & ~img_readonly;
  assign last_blk  = (buf_blk_q == BLK_W'(TRACK_BLOCKS - 1));
  assign lba_d     = ({24'd0, xfer_track_q} - 32'd1) * BLOCKS_32 + 32'(buf_blk_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_wr_q        <= 1'b0;
      xfer_track_q   <= 8'd0;
      buf_blk_q      <= '0;
      sd_lba_q       <= 32'd0;
      sd_rd_q        <= 1'b0;
      sd_wr_q        <= 1'b0;
      cur_track_q    <= 8'd0;
      track_valid_q  <= 1'b0;
      save_old_q     <= save_track;
      save_pending_q <= 1'b0;
    end else begin
      save_old_q <= save_track;
      if (save_edge) save_pending_q <= 1'b1;

      if (mounted) begin
        // New image: whatever the buffer held is stale, and any transfer is abandoned.
        track_valid_q  <= 1'b0;
        save_pending_q <= 1'b0;
        sd_rd_q        <= 1'b0;
        sd_wr_q        <= 1'b0;
        state_q        <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!img_mounted) track_valid_q <= 1'b0;
            if (save_req) begin
              save_pending_q <= 1'b0;
              if (can_save) begin
                op_wr_q      <= 1'b1;
                xfer_track_q <= cur_track_q;
                buf_blk_q    <= '0;
                state_q      <= S_REQ;
              end
            end else if (load_req) begin
              op_wr_q       <= 1'b0;
              xfer_track_q  <= track;
              track_valid_q <= 1'b0;
              buf_blk_q     <= '0;
              state_q       <= S_REQ;
            end
          end

          S_REQ: begin
            sd_lba_q <= lba_d;
            sd_rd_q  <= ~op_wr_q;
            sd_wr_q  <= op_wr_q;
            state_q  <= S_WAIT_ACK;
          end

          S_WAIT_ACK: begin
            if (sd_ack) begin
              sd_rd_q <= 1'b0;
              sd_wr_q <= 1'b0;
              state_q <= S_WAIT_DONE;
            end
          end

          S_WAIT_DONE: begin
            if (!sd_ack) begin
              if (!last_blk) begin
                buf_blk_q <= buf_blk_q + 1'b1;
                state_q   <= S_REQ;
              end else begin
                if (!op_wr_q) begin
                  cur_track_q   <= xfer_track_q;
                  track_valid_q <= 1'b1;
                end
                state_q <= S_IDLE;
              end
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign buf_blk     = buf_blk_q;
  assign cur_track   = cur_track_q;
  assign track_valid = track_valid_q;
  assign busy        = (state_q != S_IDLE);

endmodule
